// File: rtl/ctr_slice_sched.sv
// Sequencer/arbiter for NSLICE 4-bit counter slices walked one slice per cycle, carry rippled in state.
// Optional CTR_SLICE_SCHED_RR_ARB_EN: round-robin load/increment arbitration instead of load-priority.
module ctr_slice_sched #(
   parameter int NSLICE = 4,
   localparam int CW = 4 * NSLICE
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [CW-1:0] ld_data,
   input  logic          inc_valid,
   output logic          inc_ready,
   output logic [CW-1:0] cnt,
   output logic [3:0]    slice_sel,
   output logic [1:0]    slice_mode,
   output logic          busy,
   output logic          done,
   output logic          tc
);

   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [3:0] LAST = 4'(NSLICE - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b01;
   localparam logic [1:0] MODE_COUNT = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RIPPLE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  slice_q [NSLICE];
   logic [3:0]  slice_d [NSLICE];
   logic [3:0]  hold_q  [NSLICE];
   logic        done_q, done_d;
   logic        tc_q, tc_d;
   logic        rst_done_q;

   logic          ready;
   logic          grant_ld;
   logic          grant_inc;
   logic          ld_acc;
   logic          inc_acc;
   logic [IW-1:0] sidx;
   logic [3:0]    cur_slice;

   assign ready     = (state_q == IDLE) && rst_done_q;
   assign ld_ready  = ready;
   assign inc_ready = ready;

`ifdef CTR_SLICE_SCHED_RR_ARB_EN
   // last_inc_q=1 means increment won the previous accept, so a tie goes to load.
   logic last_inc_q;

   assign grant_ld  = ld_valid && (!inc_valid || last_inc_q);
   assign grant_inc = inc_valid && !grant_ld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_inc_q <= 1'b1;
      end else if (ld_acc) begin
         last_inc_q <= 1'b0;
      end else if (inc_acc) begin
         last_inc_q <= 1'b1;
      end
   end
`else
   assign grant_ld  = ld_valid;
   assign grant_inc = inc_valid && !ld_valid;
`endif

   assign ld_acc  = ready && grant_ld;
   assign inc_acc = ready && grant_inc;

   assign sidx      = idx_q[IW-1:0];
   assign cur_slice = slice_q[sidx];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      slice_d    = slice_q;
      done_d     = 1'b0;
      tc_d       = 1'b0;
      slice_sel  = 4'd0;
      slice_mode = MODE_HOLD;
      busy       = 1'b0;

      case (state_q)
         IDLE: begin
            if (ld_acc) begin
               state_d = LOAD;
               idx_d   = 4'd0;
            end else if (inc_acc) begin
               state_d = RIPPLE;
               idx_d   = 4'd0;
            end
         end

         LOAD: begin
            busy          = 1'b1;
            slice_sel     = idx_q;
            slice_mode    = MODE_LOAD;
            slice_d[sidx] = hold_q[sidx];
            if (idx_q == LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end

         RIPPLE: begin
            busy          = 1'b1;
            slice_sel     = idx_q;
            slice_mode    = MODE_COUNT;
            slice_d[sidx] = cur_slice + 4'd1;
            // Carry only propagates out of an all-ones slice; the top slice's carry is the wrap.
            if (cur_slice != 4'hF) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (idx_q == LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
               tc_d    = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 4'd0;
         done_q     <= 1'b0;
         tc_q       <= 1'b0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         done_q     <= done_d;
         tc_q       <= tc_d;
         rst_done_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLICE; i++) begin
            slice_q[i] <= 4'd0;
            hold_q[i]  <= 4'd0;
         end
      end else begin
         for (int i = 0; i < NSLICE; i++) begin
            slice_q[i] <= slice_d[i];
            if (ld_acc) begin
               hold_q[i] <= ld_data[4*i +: 4];
            end
         end
      end
   end

   for (genvar g = 0; g < NSLICE; g++) begin : g_cnt
      assign cnt[4*g +: 4] = slice_q[g];
   end

   assign done = done_q;
   assign tc   = tc_q;

endmodule

// File: tb/tb_ctr_slice_sched.sv
// Directed bench for ctr_slice_sched (NSLICE=4, default load-priority arbitration).
module tb_ctr_slice_sched;

   localparam int NSLICE = 4;
   localparam int CW = 4 * NSLICE;

   logic          clk;
   logic          rst_n;
   logic          ld_valid;
   logic          ld_ready;
   logic [CW-1:0] ld_data;
   logic          inc_valid;
   logic          inc_ready;
   logic [CW-1:0] cnt;
   logic [3:0]    slice_sel;
   logic [1:0]    slice_mode;
   logic          busy;
   logic          done;
   logic          tc;

   int tests;
   int fails;

   ctr_slice_sched #(.NSLICE(NSLICE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .inc_valid  (inc_valid),
      .inc_ready  (inc_ready),
      .cnt        (cnt),
      .slice_sel  (slice_sel),
      .slice_mode (slice_mode),
      .busy       (busy),
      .done       (done),
      .tc         (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, time=%0t required=<200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Loads a value and returns one cycle after its done pulse.
   task automatic do_load(input logic [CW-1:0] v);
      ld_data  = v;
      ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      repeat (NSLICE) tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      ld_valid  = 1'b0;
      inc_valid = 1'b0;
      ld_data   = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (cnt !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: cnt=%h busy=%b done=%b tc=%b required cnt=0000 busy=0 done=0 tc=0",
                  cnt, busy, done, tc);
      end
      tests++;
      if (ld_ready !== 1'b0 || inc_ready !== 1'b0 || slice_mode !== 2'b00 || slice_sel !== 4'd0) begin
         fails++;
         $display("FAIL reset_ready: ld_ready=%b inc_ready=%b mode=%b sel=%0d required 0 0 00 0",
                  ld_ready, inc_ready, slice_mode, slice_sel);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (ld_ready !== 1'b0 || inc_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_before_first_edge: ld_ready=%b inc_ready=%b required 0 0", ld_ready, inc_ready);
      end
      tick();
      tests++;
      if (ld_ready !== 1'b1 || inc_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cnt !== 16'h0000) begin
         fails++;
         $display("FAIL ready_after_reset: ld_ready=%b inc_ready=%b busy=%b done=%b cnt=%h required 1 1 0 0 0000",
                  ld_ready, inc_ready, busy, done, cnt);
      end
   endtask

   task automatic test_load();
      ld_data  = 16'h12EF;
      ld_valid = 1'b1;
      tests++;
      if (ld_ready !== 1'b1) begin
         fails++;
         $display("FAIL load_accept_ready: ld_ready=%b required 1", ld_ready);
      end
      tick();
      ld_valid = 1'b0;
      for (int i = 0; i < NSLICE; i++) begin
         tests++;
         if (slice_sel !== 4'(i) || slice_mode !== 2'b01 || busy !== 1'b1 || ld_ready !== 1'b0) begin
            fails++;
            $display("FAIL load_cycle%0d: sel=%0d mode=%b busy=%b ld_ready=%b required sel=%0d mode=01 busy=1 ld_ready=0",
                     i, slice_sel, slice_mode, busy, ld_ready, i);
         end
         tick();
      end
      tests++;
      if (done !== 1'b1 || tc !== 1'b0 || busy !== 1'b0 || cnt !== 16'h12EF || ld_ready !== 1'b1) begin
         fails++;
         $display("FAIL load_done: done=%b tc=%b busy=%b cnt=%h ld_ready=%b required 1 0 0 12ef 1",
                  done, tc, busy, cnt, ld_ready);
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL load_done_width: done=%b required 0", done);
      end
   endtask

   task automatic test_inc_carry();
      inc_valid = 1'b1;
      tick();
      inc_valid = 1'b0;
      tests++;
      if (slice_sel !== 4'd0 || slice_mode !== 2'b11 || busy !== 1'b1) begin
         fails++;
         $display("FAIL inc_cycle0: sel=%0d mode=%b busy=%b required 0 11 1", slice_sel, slice_mode, busy);
      end
      tick();
      tests++;
      if (slice_sel !== 4'd1 || slice_mode !== 2'b11 || cnt !== 16'h12E0) begin
         fails++;
         $display("FAIL inc_cycle1: sel=%0d mode=%b cnt=%h required 1 11 12e0", slice_sel, slice_mode, cnt);
      end
      tick();
      tests++;
      if (done !== 1'b1 || tc !== 1'b0 || busy !== 1'b0 || cnt !== 16'h12F0) begin
         fails++;
         $display("FAIL inc_carry_done: done=%b tc=%b busy=%b cnt=%h required 1 0 0 12f0", done, tc, busy, cnt);
      end
      tick();
   endtask

   task automatic test_inc_single();
      inc_valid = 1'b1;
      tick();
      inc_valid = 1'b0;
      tick();
      tests++;
      if (done !== 1'b1 || tc !== 1'b0 || busy !== 1'b0 || cnt !== 16'h12F1) begin
         fails++;
         $display("FAIL inc_single: done=%b tc=%b busy=%b cnt=%h required 1 0 0 12f1", done, tc, busy, cnt);
      end
      tick();
   endtask

   task automatic test_wrap();
      do_load(16'hFFFF);
      inc_valid = 1'b1;
      tick();
      inc_valid = 1'b0;
      for (int i = 0; i < NSLICE; i++) begin
         tests++;
         if (slice_sel !== 4'(i) || slice_mode !== 2'b11 || done !== 1'b0 || tc !== 1'b0) begin
            fails++;
            $display("FAIL wrap_cycle%0d: sel=%0d mode=%b done=%b tc=%b required sel=%0d mode=11 done=0 tc=0",
                     i, slice_sel, slice_mode, done, tc, i);
         end
         tick();
      end
      tests++;
      if (done !== 1'b1 || tc !== 1'b1 || cnt !== 16'h0000 || busy !== 1'b0) begin
         fails++;
         $display("FAIL wrap_done: done=%b tc=%b cnt=%h busy=%b required 1 1 0000 0", done, tc, cnt, busy);
      end
      tick();
      tests++;
      if (done !== 1'b0 || tc !== 1'b0) begin
         fails++;
         $display("FAIL wrap_pulse_width: done=%b tc=%b required 0 0", done, tc);
      end
   endtask

   task automatic test_back_to_back_tie();
      ld_data   = 16'h0005;
      ld_valid  = 1'b1;
      inc_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
      tests++;
      if (slice_mode !== 2'b01 || inc_ready !== 1'b0) begin
         fails++;
         $display("FAIL tie_winner: mode=%b inc_ready=%b required 01 0", slice_mode, inc_ready);
      end
      repeat (NSLICE) tick();
      tests++;
      if (done !== 1'b1 || cnt !== 16'h0005 || inc_ready !== 1'b1) begin
         fails++;
         $display("FAIL tie_load_done: done=%b cnt=%h inc_ready=%b required 1 0005 1", done, cnt, inc_ready);
      end
      tick();
      inc_valid = 1'b0;
      tests++;
      if (slice_mode !== 2'b11 || slice_sel !== 4'd0) begin
         fails++;
         $display("FAIL tie_loser_served: mode=%b sel=%0d required 11 0", slice_mode, slice_sel);
      end
      tick();
      tests++;
      if (done !== 1'b1 || cnt !== 16'h0006 || tc !== 1'b0) begin
         fails++;
         $display("FAIL tie_final: done=%b cnt=%h tc=%b required 1 0006 0", done, cnt, tc);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_load(16'hFFFF);
      inc_valid = 1'b1;
      tick();
      inc_valid = 1'b0;
      tick();
      tick();
      tests++;
      if (slice_sel !== 4'd2 || slice_mode !== 2'b11) begin
         fails++;
         $display("FAIL mid_third_cycle: sel=%0d mode=%b required 2 11", slice_sel, slice_mode);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (cnt !== 16'h0000 || busy !== 1'b0 || slice_mode !== 2'b00 || ld_ready !== 1'b0) begin
         fails++;
         $display("FAIL mid_abort: cnt=%h busy=%b mode=%b ld_ready=%b required 0000 0 00 0",
                  cnt, busy, slice_mode, ld_ready);
      end
      tick();
      tests++;
      if (done !== 1'b0 || tc !== 1'b0) begin
         fails++;
         $display("FAIL mid_no_pulse: done=%b tc=%b required 0 0", done, tc);
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (done !== 1'b0 || tc !== 1'b0 || inc_ready !== 1'b1 || cnt !== 16'h0000) begin
         fails++;
         $display("FAIL mid_release: done=%b tc=%b inc_ready=%b cnt=%h required 0 0 1 0000",
                  done, tc, inc_ready, cnt);
      end
      inc_valid = 1'b1;
      tick();
      inc_valid = 1'b0;
      tick();
      tests++;
      if (done !== 1'b1 || tc !== 1'b0 || cnt !== 16'h0001) begin
         fails++;
         $display("FAIL mid_next_inc: done=%b tc=%b cnt=%h required 1 0 0001", done, tc, cnt);
      end
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_load();
      test_inc_carry();
      test_inc_single();
      test_wrap();
      test_back_to_back_tie();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
